// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared encodings for the serial add/subtract sequencer
package addsub_pkg;

    localparam int   NIBBLE_W = 4;
    localparam logic OP_ADD   = 1'b0;
    localparam logic OP_SUB   = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_addsub_ctrl_if.sv
// rtl/serial_addsub_ctrl_if.sv - command/result handshake bundle for serial_addsub_ctrl
interface serial_addsub_ctrl_if #(
    parameter int W = 16
);
    logic         start_valid;
    logic         start_ready;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;

    modport master (
        output start_valid, op, a, b, res_ready,
        input  start_ready, res_valid, res, cout, ovf
    );

    modport slave (
        input  start_valid, op, a, b, res_ready,
        output start_ready, res_valid, res, cout, ovf
    );
endinterface

// File: rtl/fadder.sv
// rtl/fadder.sv - single-bit full adder
module fadder (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);
    assign sum_o  = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
endmodule

// File: rtl/nibble_add.sv
// rtl/nibble_add.sv - 4-bit ripple adder with an independent carry-in
module nibble_add
    import addsub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a_i,
    input  logic [NIBBLE_W-1:0] b_i,
    input  logic                cin_i,
    output logic [NIBBLE_W-1:0] sum_o,
    output logic                cout_o
);
    logic [NIBBLE_W:0] carry;

    assign carry[0] = cin_i;
    assign cout_o   = carry[NIBBLE_W];

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
        fadder u_fa (
            .a_i   (a_i[i]),
            .b_i   (b_i[i]),
            .cin_i (carry[i]),
            .sum_o (sum_o[i]),
            .cout_o(carry[i+1])
        );
    end
endmodule

// File: rtl/serial_addsub_ctrl.sv
// rtl/serial_addsub_ctrl.sv - multi-precision add/subtract, one nibble per clock, LSB first
module serial_addsub_ctrl
    import addsub_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_addsub_ctrl_if.slave  bus
);
    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              carry_q, carry_d;
    logic              op_q, op_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [W-1:0]      res_q, res_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic [NIBBLE_W-1:0] a_nib;
    logic [NIBBLE_W-1:0] b_nib;
    logic [NIBBLE_W-1:0] sum;
    logic                slice_cout;

    // b_nib is already inverted for subtract, so the slice and the overflow test see B'.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_nib = a_q[i*NIBBLE_W +: NIBBLE_W];
                b_nib = b_q[i*NIBBLE_W +: NIBBLE_W] ^ {NIBBLE_W{op_q}};
            end
        end
    end

    nibble_add u_slice (
        .a_i   (a_nib),
        .b_i   (b_nib),
        .cin_i (carry_q),
        .sum_o (sum),
        .cout_o(slice_cout)
    );

    assign bus.start_ready = (state_q == S_IDLE);
    assign bus.res_valid   = (state_q == S_DONE);
    assign bus.res         = res_q;
    assign bus.cout        = cout_q;
    assign bus.ovf         = ovf_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    op_d    = bus.op;
                    carry_d = bus.op;
                    idx_d   = '0;
                    res_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IDX_W'(i)) res_d[i*NIBBLE_W +: NIBBLE_W] = sum;
                end
                carry_d = slice_cout;
                if (idx_q == IDX_LAST) begin
                    cout_d  = slice_cout;
                    ovf_d   = (a_nib[NIBBLE_W-1] == b_nib[NIBBLE_W-1]) &&
                              (sum[NIBBLE_W-1] != a_nib[NIBBLE_W-1]);
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_DONE: begin
                if (bus.res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// tb/tb_serial_addsub_ctrl.sv - self-checking bench for serial_addsub_ctrl
module tb_serial_addsub_ctrl;
    import addsub_pkg::*;

    localparam int N = 4;
    localparam int W = 16;

    typedef struct {
        logic         op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_addsub_ctrl_if #(.W(W)) bus ();
    serial_addsub_ctrl_if #(.W(4)) bus1 ();

    serial_addsub_ctrl #(.NIBBLES(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    serial_addsub_ctrl #(.NIBBLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    vec_t tv[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t m;
        int sa, sb, r;
        sa     = int'($signed(a));
        sb     = int'($signed(b));
        r      = op ? sa - sb : sa + sb;
        m.res  = W'(r);
        m.ovf  = (r > 32767) || (r < -32768);
        m.cout = op ? (a >= b) : ((32'(a) + 32'(b)) > 32'h0000_FFFF);
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one command, queues its expectation, returns cycles from accept to res_valid.
    task automatic send(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input exp_t e, output int lat);
        int n;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        bus.start_valid = 1'b1;
        n = 0;
        while (!bus.start_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) chk("accept_timeout", 32'(n), 32'd0);
        sbq.push_back(e);
        step();
        bus.start_valid = 1'b0;
        lat = 0;
        while (!bus.res_valid && lat < 100) begin
            step();
            lat++;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            step();
            n++;
        end
        chk("drain_pending", 32'(sbq.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.res_valid && bus.res_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got 0x%0h expected none", bus.res);
            end else begin
                e = sbq.pop_front();
                chk("res", 32'(bus.res), 32'(e.res));
                chk("cout", 32'(bus.cout), 32'(e.cout));
                chk("ovf", 32'(bus.ovf), 32'(e.ovf));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int   lat;
        exp_t e;
        logic [W-1:0] ra, rb;
        logic rop;

        tv[0] = '{OP_ADD, 16'h1234, 16'h0FCD, 16'h2201, 1'b0, 1'b0};
        tv[1] = '{OP_SUB, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
        tv[2] = '{OP_SUB, 16'h0007, 16'h0005, 16'h0002, 1'b1, 1'b0};
        tv[3] = '{OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
        tv[4] = '{OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
        tv[5] = '{OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};

        bus.start_valid = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0; bus.res_ready = 1'b1;
        bus1.start_valid = 1'b0; bus1.op = 1'b0; bus1.a = '0; bus1.b = '0; bus1.res_ready = 1'b1;

        #12;
        chk("rst_res", 32'(bus.res), 32'd0);
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_cout", 32'(bus.cout), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        chk("rst_start_ready", 32'(bus.start_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            e.res = tv[i].res; e.cout = tv[i].cout; e.ovf = tv[i].ovf;
            send(tv[i].op, tv[i].a, tv[i].b, e, lat);
            chk($sformatf("latency_vec%0d", i), 32'(lat), 32'(N));
            drain();
            step();
        end

        for (int i = 0; i < 20; i++) begin
            rop = 1'($urandom_range(0, 1));
            ra  = W'($urandom_range(0, 65535));
            rb  = W'($urandom_range(0, 65535));
            send(rop, ra, rb, model(rop, ra, rb), lat);
            drain();
            step();
        end

        // Backpressure window with an ignored start pulse, then simultaneous res/start handshake.
        bus.res_ready = 1'b0;
        send(OP_ADD, 16'h1111, 16'h2222, '{16'h3333, 1'b0, 1'b0}, lat);
        chk("bp_latency", 32'(lat), 32'(N));
        for (int k = 0; k < 3; k++) begin
            bus.start_valid = (k == 1);
            bus.op = OP_ADD; bus.a = 16'hAAAA; bus.b = 16'h0001;
            step();
            chk("bp_res_hold", 32'(bus.res), 32'h3333);
            chk("bp_cout_hold", 32'(bus.cout), 32'd0);
            chk("bp_ovf_hold", 32'(bus.ovf), 32'd0);
            chk("bp_res_valid", 32'(bus.res_valid), 32'd1);
            chk("bp_start_ready", 32'(bus.start_ready), 32'd0);
        end
        bus.res_ready = 1'b1;
        bus.start_valid = 1'b1;
        bus.op = OP_SUB; bus.a = 16'h0010; bus.b = 16'h0001;
        sbq.push_back('{16'h000F, 1'b1, 1'b0});
        chk("sim_ready_in_done", 32'(bus.start_ready), 32'd0);
        step();
        chk("sim_bubble_ready", 32'(bus.start_ready), 32'd1);
        chk("sim_bubble_valid", 32'(bus.res_valid), 32'd0);
        step();
        bus.start_valid = 1'b0;
        chk("sim_accepted", 32'(bus.start_ready), 32'd0);
        lat = 0;
        while (!bus.res_valid && lat < 100) begin
            step();
            lat++;
        end
        chk("sim_latency", 32'(lat), 32'(N));
        drain();
        step();

        // Reset two nibbles into an operation; prior cout=1 must be cleared.
        bus.op = OP_ADD; bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.start_valid = 1'b1;
        chk("mr_start_ready", 32'(bus.start_ready), 32'd1);
        step();
        bus.start_valid = 1'b0;
        step();
        step();
        chk("mr_partial_res", 32'(bus.res), 32'h00FE);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_res", 32'(bus.res), 32'd0);
        chk("mr_res_valid", 32'(bus.res_valid), 32'd0);
        chk("mr_cout", 32'(bus.cout), 32'd0);
        chk("mr_ovf", 32'(bus.ovf), 32'd0);
        chk("mr_start_ready", 32'(bus.start_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        send(OP_ADD, 16'h0001, 16'h0001, '{16'h0002, 1'b0, 1'b0}, lat);
        chk("mr_new_latency", 32'(lat), 32'(N));
        drain();
        step();

        // Single-nibble build.
        for (int i = 0; i < 2; i++) begin
            bus1.op = (i == 0) ? OP_ADD : OP_SUB;
            bus1.a  = (i == 0) ? 4'h9 : 4'h3;
            bus1.b  = (i == 0) ? 4'h8 : 4'h5;
            bus1.start_valid = 1'b1;
            chk("n1_start_ready", 32'(bus1.start_ready), 32'd1);
            step();
            bus1.start_valid = 1'b0;
            chk("n1_run_valid", 32'(bus1.res_valid), 32'd0);
            step();
            chk("n1_done_valid", 32'(bus1.res_valid), 32'd1);
            chk("n1_res", 32'(bus1.res), (i == 0) ? 32'h1 : 32'hE);
            chk("n1_cout", 32'(bus1.cout), (i == 0) ? 32'd1 : 32'd0);
            chk("n1_ovf", 32'(bus1.ovf), (i == 0) ? 32'd1 : 32'd0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
